// File: rtl/ym3438_pg_seq_if.sv
// ym3438_pg_seq_if
//   Bus between the register write decoder / sequencer driver and the PG
//   slot sequencer.
//   master: drives c1, c2, wr_en, wr_addr, wr_data; receives slot outputs.
//   slave : the sequencer; receives strobes/writes, drives per-slot outputs.
//   Signals:
//     c1, c2    phase enables, one MCLK wide, never coincident
//     wr_en     register write strobe
//     wr_addr   {part, addr[7:0]}
//     wr_data   write data
//     slot      slot presented (0..23)
//     fnum      raw 11-bit fnum, zero-extended to 12 bits
//     block     block of the slot
//     multi     multiple of the slot
//     dt        detune code {sign, mag[1:0]}
//     kcode     {block, fnum[10], fnum[10] ? |fnum[9:7] : &fnum[9:7]}
//     pg_reset  1 = accumulate phase, 0 = clear phase
//     sync      high while slot == 0
interface ym3438_pg_seq_if;
   logic        c1;
   logic        c2;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [4:0]  slot;
   logic [11:0] fnum;
   logic [2:0]  block;
   logic [3:0]  multi;
   logic [2:0]  dt;
   logic [4:0]  kcode;
   logic        pg_reset;
   logic        sync;

   modport master (
      output c1, c2, wr_en, wr_addr, wr_data,
      input  slot, fnum, block, multi, dt, kcode, pg_reset, sync
   );

   modport slave (
      input  c1, c2, wr_en, wr_addr, wr_data,
      output slot, fnum, block, multi, dt, kcode, pg_reset, sync
   );
endinterface

// File: rtl/ym3438_pg_seq.sv
// ym3438_pg_seq
//   Slot sequencer and parameter store for the phase generator. Stores
//   fnum/block per channel, CH3 special-mode fnums, dt/multi per operator
//   and key-on state, walks the 24 operator slots (one per c1/c2 pair) and
//   presents the current slot's parameters to the PG.
//   Ports:
//     MCLK   master clock
//     reset  synchronous, active-high reset
//     bus    ym3438_pg_seq_if.slave (strobes, register writes, slot outputs)
//   Slot numbering: slot = 6*opidx + ch, opidx order OP1,OP3,OP2,OP4.
module ym3438_pg_seq #(
   parameter int unsigned SLOTS    = 24,
   parameter int unsigned KC_WIDTH = 5
) (
   input  logic              MCLK,
   input  logic              reset,
   ym3438_pg_seq_if.slave    bus
);

   logic [4:0]  r_cnt;
   logic [10:0] r_fnum     [6];
   logic [2:0]  r_block    [6];
   logic [10:0] r_sp_fnum  [3];
   logic [2:0]  r_sp_block [3];
   logic [2:0]  r_dt       [24];
   logic [3:0]  r_multi    [24];
   logic [23:0] r_key;
   logic [23:0] r_key_prev;
   logic [5:0]  r_hi;
   logic [5:0]  r_hi3;
   logic [1:0]  r_mode;

   // ---------------- write decode ----------------
   logic       w_part;
   logic [7:0] w_a;
   logic [1:0] w_lo;
   logic       w_lo_ok;
   logic [2:0] w_wr_ch;
   logic [4:0] w_op_slot;
   logic [1:0] w_sp_k;
   logic [2:0] w_key_ch;
   logic       w_key_ok;

   always_comb begin
      w_part    = bus.wr_addr[8];
      w_a       = bus.wr_addr[7:0];
      w_lo      = w_a[1:0];
      w_lo_ok   = (w_lo != 2'd3);
      w_wr_ch   = w_part ? (3'd3 + {1'b0, w_lo}) : {1'b0, w_lo};
      // addr[3:2] already follows slot operator order, so slot = 6*addr[3:2] + ch
      w_op_slot = {1'b0, w_a[3:2], 2'b00} + {2'b00, w_a[3:2], 1'b0} + {2'b00, w_wr_ch};
      // A9 = OP1 (k0), A8 = OP3 (k1), AA = OP2 (k2): k matches opidx
      w_sp_k    = (w_lo == 2'd1) ? 2'd0 : ((w_lo == 2'd0) ? 2'd1 : 2'd2);
      w_key_ch  = bus.wr_data[2] ? (3'd3 + {1'b0, bus.wr_data[1:0]}) : {1'b0, bus.wr_data[1:0]};
      w_key_ok  = (bus.wr_data[1:0] != 2'd3);
   end

   // ---------------- read decode for the current slot ----------------
   logic [1:0]          w_rd_op;
   logic [2:0]          w_rd_ch;
   logic                w_use_sp;
   logic [10:0]         w_fnum;
   logic [2:0]          w_block;
   logic [KC_WIDTH-1:0] w_kcode;

   always_comb begin
      w_rd_op = 2'd0;
      w_rd_ch = r_cnt[2:0];
      if (r_cnt >= 5'd18) begin
         w_rd_op = 2'd3;
         w_rd_ch = 3'(r_cnt - 5'd18);
      end else if (r_cnt >= 5'd12) begin
         w_rd_op = 2'd2;
         w_rd_ch = 3'(r_cnt - 5'd12);
      end else if (r_cnt >= 5'd6) begin
         w_rd_op = 2'd1;
         w_rd_ch = 3'(r_cnt - 5'd6);
      end
      w_use_sp = (r_mode != 2'd0) && (w_rd_ch == 3'd2) && (w_rd_op != 2'd3);
      if (w_use_sp) begin
         w_fnum  = r_sp_fnum[w_rd_op];
         w_block = r_sp_block[w_rd_op];
      end else begin
         w_fnum  = r_fnum[w_rd_ch];
         w_block = r_block[w_rd_ch];
      end
      w_kcode = {w_block, w_fnum[10],
                 w_fnum[10] ? (|w_fnum[9:7]) : (&w_fnum[9:7])};
   end

   // ---------------- state ----------------
   always_ff @(posedge MCLK) begin
      if (reset) begin
         r_cnt        <= '0;
         r_key        <= '0;
         r_key_prev   <= '0;
         r_hi         <= '0;
         r_hi3        <= '0;
         r_mode       <= '0;
         for (int unsigned i = 0; i < 6; i++) begin
            r_fnum[i]  <= '0;
            r_block[i] <= '0;
         end
         for (int unsigned i = 0; i < 3; i++) begin
            r_sp_fnum[i]  <= '0;
            r_sp_block[i] <= '0;
         end
         for (int unsigned i = 0; i < 24; i++) begin
            r_dt[i]    <= '0;
            r_multi[i] <= '0;
         end
         bus.slot     <= '0;
         bus.fnum     <= '0;
         bus.block    <= '0;
         bus.multi    <= '0;
         bus.dt       <= '0;
         bus.kcode    <= '0;
         bus.pg_reset <= 1'b1;
         bus.sync     <= 1'b1;
      end else begin
         if (bus.c2)
            r_cnt <= (r_cnt == 5'(SLOTS - 1)) ? 5'd0 : r_cnt + 5'd1;

         // Outputs sample the stored state before any write in this MCLK lands
         if (bus.c1) begin
            bus.slot          <= r_cnt;
            bus.fnum          <= {1'b0, w_fnum};
            bus.block         <= w_block;
            bus.multi         <= r_multi[r_cnt];
            bus.dt            <= r_dt[r_cnt];
            bus.kcode         <= w_kcode;
            bus.pg_reset      <= ~(r_key[r_cnt] & ~r_key_prev[r_cnt]);
            bus.sync          <= (r_cnt == 5'd0);
            r_key_prev[r_cnt] <= r_key[r_cnt];
         end

         if (bus.wr_en && w_lo_ok) begin
            if (w_a[7:4] == 4'h3) begin
               r_dt[w_op_slot]    <= bus.wr_data[6:4];
               r_multi[w_op_slot] <= bus.wr_data[3:0];
            end
            if (w_a[7:2] == 6'b1010_01)           // A4-A6
               r_hi <= bus.wr_data[5:0];
            if (w_a[7:2] == 6'b1010_00) begin     // A0-A2
               r_fnum[w_wr_ch]  <= {r_hi[2:0], bus.wr_data};
               r_block[w_wr_ch] <= r_hi[5:3];
            end
            if (!w_part) begin
               if (w_a[7:2] == 6'b1010_11)        // AC-AE
                  r_hi3 <= bus.wr_data[5:0];
               if (w_a[7:2] == 6'b1010_10) begin  // A8-AA
                  r_sp_fnum[w_sp_k]  <= {r_hi3[2:0], bus.wr_data};
                  r_sp_block[w_sp_k] <= r_hi3[5:3];
               end
            end
         end

         if (bus.wr_en && !w_part) begin
            if (w_a == 8'h27)
               r_mode <= bus.wr_data[7:6];
            if (w_a == 8'h28 && w_key_ok) begin
               r_key[5'd0  + {2'b00, w_key_ch}] <= bus.wr_data[4];  // OP1
               r_key[5'd6  + {2'b00, w_key_ch}] <= bus.wr_data[6];  // OP3
               r_key[5'd12 + {2'b00, w_key_ch}] <= bus.wr_data[5];  // OP2
               r_key[5'd18 + {2'b00, w_key_ch}] <= bus.wr_data[7];  // OP4
            end
         end
      end
   end

endmodule

// File: tb/tb_ym3438_pg_seq.sv
// tb_ym3438_pg_seq
//   Directed table-driven bench for ym3438_pg_seq plus hand sequences for
//   key-on edges, CH3 special mode, read-before-write and mid-frame reset.
module tb_ym3438_pg_seq;

   logic MCLK;
   logic reset;
   ym3438_pg_seq_if bus ();

   ym3438_pg_seq #(.SLOTS(24), .KC_WIDTH(5)) dut (
      .MCLK  (MCLK),
      .reset (reset),
      .bus   (bus)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   int n_checks;
   int n_errors;
   int tb_cnt;

   typedef struct {
      bit          we;
      logic [8:0]  addr;
      logic [7:0]  data;
      int          slot;
      logic [11:0] fnum;
      logic [2:0]  block;
      logic [3:0]  multi;
      logic [2:0]  dt;
      logic [4:0]  kcode;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input int s, input logic [11:0] f, input logic [2:0] b,
                          input logic [3:0] m, input logic [2:0] d, input logic [4:0] k,
                          input logic pg);
      chk("slot",     32'(bus.slot),     32'(s));
      chk("sync",     32'(bus.sync),     32'(s == 0));
      chk("fnum",     32'(bus.fnum),     32'(f));
      chk("block",    32'(bus.block),    32'(b));
      chk("multi",    32'(bus.multi),    32'(m));
      chk("dt",       32'(bus.dt),       32'(d));
      chk("kcode",    32'(bus.kcode),    32'(k));
      chk("pg_reset", 32'(bus.pg_reset), 32'(pg));
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      @(negedge MCLK);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(negedge MCLK);
      bus.wr_en = 1'b0;
   endtask

   task automatic present();
      @(negedge MCLK);
      bus.c1 = 1'b1;
      @(negedge MCLK);
      bus.c1 = 1'b0;
   endtask

   task automatic finish_slot();
      @(negedge MCLK);
      bus.c2 = 1'b1;
      @(negedge MCLK);
      bus.c2 = 1'b0;
      tb_cnt = (tb_cnt + 1) % 24;
   endtask

   task automatic advance_to(input int s);
      int guard;
      guard = 0;
      while (tb_cnt != s && guard < 48) begin
         present();
         finish_slot();
         guard++;
      end
      if (tb_cnt != s) begin
         n_checks++;
         n_errors++;
         $display("FAIL advance: bench slot %0d never reached %0d", tb_cnt, s);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      tb_cnt   = 0;
      reset = 1'b1;
      bus.c1 = 1'b0; bus.c2 = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

      //          we  addr    data   slot fnum    blk mul dt kcode
      vecs[0]  = '{1, 9'h0A4, 8'h22, 0, 12'h000, 0, 0,  0, 5'h00};
      vecs[1]  = '{1, 9'h0A0, 8'h69, 0, 12'h269, 4, 0,  0, 5'h10};
      vecs[2]  = '{1, 9'h034, 8'h15, 6, 12'h269, 4, 5,  1, 5'h10};
      vecs[3]  = '{0, 9'h000, 8'h00, 7, 12'h000, 0, 0,  0, 5'h00};
      vecs[4]  = '{1, 9'h13C, 8'h7F, 21, 12'h000, 0, 15, 7, 5'h00};
      vecs[5]  = '{1, 9'h0A5, 8'h3F, 4, 12'h000, 0, 0,  0, 5'h00};
      vecs[6]  = '{1, 9'h1A1, 8'hFF, 4, 12'h7FF, 7, 0,  0, 5'h1F};
      vecs[7]  = '{1, 9'h0A4, 8'h03, 2, 12'h000, 0, 0,  0, 5'h00};
      vecs[8]  = '{1, 9'h0A2, 8'h80, 2, 12'h380, 0, 0,  0, 5'h01};
      vecs[9]  = '{1, 9'h0A4, 8'h3F, 1, 12'h000, 0, 0,  0, 5'h00};
      vecs[10] = '{1, 9'h0A4, 8'h0C, 1, 12'h000, 0, 0,  0, 5'h00};
      vecs[11] = '{1, 9'h0A1, 8'h00, 1, 12'h400, 1, 0,  0, 5'h06};
      vecs[12] = '{1, 9'h033, 8'hFF, 3, 12'h000, 0, 0,  0, 5'h00};
      vecs[13] = '{1, 9'h0A3, 8'hFF, 3, 12'h000, 0, 0,  0, 5'h00};
      vecs[14] = '{1, 9'h0A7, 8'h3F, 0, 12'h269, 4, 0,  0, 5'h10};
      vecs[15] = '{1, 9'h0A0, 8'h55, 0, 12'h455, 1, 0,  0, 5'h06};
      vecs[16] = '{1, 9'h128, 8'hF1, 1, 12'h400, 1, 0,  0, 5'h06};
      vecs[17] = '{1, 9'h127, 8'hC0, 2, 12'h380, 0, 0,  0, 5'h01};

      repeat (3) @(negedge MCLK);
      reset = 1'b0;
      @(negedge MCLK);

      // reset state
      chk_out(0, 12'h000, 0, 0, 0, 5'h00, 1'b1);

      // one full frame plus wrap
      for (int i = 0; i < 24; i++) begin
         present();
         chk("sweep slot",  32'(bus.slot),     32'(i));
         chk("sweep sync",  32'(bus.sync),     32'(i == 0));
         chk("sweep pg",    32'(bus.pg_reset), 32'd1);
         finish_slot();
      end
      present();
      chk("wrap slot", 32'(bus.slot), 32'd0);
      chk("wrap sync", 32'(bus.sync), 32'd1);
      finish_slot();

      // table-driven writes
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
         advance_to(vecs[i].slot);
         present();
         chk_out(vecs[i].slot, vecs[i].fnum, vecs[i].block, vecs[i].multi,
                 vecs[i].dt, vecs[i].kcode, 1'b1);
         finish_slot();
      end

      // CH3 special mode: OP1..OP3 take A9/A8/AA, OP4 keeps the channel fnum
      wr(9'h027, 8'h40);
      wr(9'h0AE, 8'h0B);
      wr(9'h0AA, 8'h34);
      advance_to(14); present(); chk_out(14, 12'h334, 1, 0, 0, 5'h04, 1'b1); finish_slot();
      advance_to(20); present(); chk_out(20, 12'h380, 0, 0, 0, 5'h01, 1'b1); finish_slot();
      advance_to(2);  present(); chk_out(2,  12'h000, 0, 0, 0, 5'h00, 1'b1); finish_slot();
      wr(9'h0A8, 8'h12);
      advance_to(8);  present(); chk_out(8,  12'h312, 1, 0, 0, 5'h04, 1'b1); finish_slot();
      wr(9'h027, 8'h00);
      advance_to(14); present(); chk_out(14, 12'h380, 0, 0, 0, 5'h01, 1'b1); finish_slot();
      advance_to(20); present(); chk_out(20, 12'h380, 0, 0, 0, 5'h01, 1'b1); finish_slot();

      // key-on CH1 all ops: phase clear once per slot, first frame only
      advance_to(0);
      wr(9'h028, 8'hF0);
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 24; s++) begin
            present();
            chk("key slot", 32'(bus.slot), 32'(s));
            chk("key pg",   32'(bus.pg_reset), 32'(!(f == 0 && (s % 6) == 0)));
            finish_slot();
         end
      end
      // key-off CH1 (no effect), key-on CH4 OP1 (slot 3)
      wr(9'h028, 8'h00);
      wr(9'h028, 8'h14);
      for (int s = 0; s < 24; s++) begin
         present();
         chk("key2 pg", 32'(bus.pg_reset), 32'(s != 3));
         finish_slot();
      end

      // write in the same MCLK as c1 of its slot: old value latched
      advance_to(0);
      @(negedge MCLK);
      bus.c1 = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 9'h030; bus.wr_data = 8'h0A;
      @(negedge MCLK);
      bus.c1 = 1'b0; bus.wr_en = 1'b0;
      chk("rbw old multi", 32'(bus.multi), 32'd0);
      finish_slot();
      advance_to(0);
      present();
      chk("rbw new multi", 32'(bus.multi), 32'd10);
      finish_slot();

      // reset mid-frame at slot 13
      advance_to(13);
      present();
      chk("pre-reset slot", 32'(bus.slot), 32'd13);
      @(negedge MCLK);
      reset = 1'b1;
      @(negedge MCLK);
      reset = 1'b0;
      chk_out(0, 12'h000, 0, 0, 0, 5'h00, 1'b1);
      tb_cnt = 0;
      present();
      chk_out(0, 12'h000, 0, 0, 0, 5'h00, 1'b1);
      finish_slot();
      present();
      chk_out(1, 12'h000, 0, 0, 0, 5'h00, 1'b1);
      finish_slot();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
